// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares a single common data bus (CDB) between the ALU and the load/store
//   buffer (LSB). Each source has a small holding FIFO so a result that loses
//   arbitration is not dropped. When a source's FIFO is empty, its
//   transferring result bypasses the FIFO and can win the bus immediately.
//   A broadcast then appears on cdb_* one cycle after the transfer.
//
//   Contention policy: round-robin by default. The source that was not
//   granted at the last contended cycle wins. After reset or a flush, the
//   ALU wins the first contention.
//   Build option: define CDB_ARB_FIXED_PRI_EN to make the LSB always win
//   contention. No grant history is kept in that build.
//
// Parameters
//   ROB_W   ROB tag width
//   DATA_W  result value width
//   DEPTH   holding FIFO entries per source (power of two, >= 2)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global ready; low freezes FIFOs and grant history
//   clr                      flush: empties both FIFOs, drops this cycle's inputs
//   alu_valid/rob/value      ALU result offer
//   alu_ready                ALU FIFO can accept (combinational)
//   lsb_valid/rob/value      LSB result offer
//   lsb_ready                LSB FIFO can accept (combinational)
//   cdb_valid/rob/value/src  registered broadcast; src 0 = ALU, 1 = LSB
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_rob,
  input  logic [DATA_W-1:0] alu_value,
  output logic              alu_ready,
  input  logic              lsb_valid,
  input  logic [ROB_W-1:0]  lsb_rob,
  input  logic [DATA_W-1:0] lsb_value,
  output logic              lsb_ready,
  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_rob,
  output logic [DATA_W-1:0] cdb_value,
  output logic              cdb_src
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ENT_W  = ROB_W + DATA_W;

  // The bus is live only when not in reset, not flushing, and not frozen.
  logic active;
  assign active = rdy & ~clr & ~rst;

  // Per-source views. Index 0 is the ALU and index 1 is the LSB, so the
  // index doubles as the cdb_src encoding.
  logic [1:0]             in_valid;
  logic [1:0][ROB_W-1:0]  in_rob;
  logic [1:0][DATA_W-1:0] in_value;
  logic [1:0]             ready_w;
  logic [1:0]             fifo_empty;
  logic [1:0]             cand_valid;
  logic [1:0][ROB_W-1:0]  cand_rob;
  logic [1:0][DATA_W-1:0] cand_value;
  logic [1:0]             win;

  assign in_valid = {lsb_valid, alu_valid};
  assign in_rob   = {lsb_rob, alu_rob};
  assign in_value = {lsb_value, alu_value};

  assign alu_ready = ready_w[0];
  assign lsb_ready = ready_w[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      logic [ENT_W-1:0]  mem_reg [DEPTH];
      logic [ADDR_W-1:0] wr_ptr_reg;
      logic [ADDR_W-1:0] rd_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic              xfer;
      logic              push;
      logic              pop;

      assign ready_w[gi]    = active & (count_reg < CNT_W'(DEPTH));
      assign xfer           = in_valid[gi] & ready_w[gi];
      assign fifo_empty[gi] = (count_reg == '0);

      // Held results go ahead of a new arrival, which keeps source order.
      assign cand_valid[gi] = ~fifo_empty[gi] | xfer;
      assign cand_rob[gi]   = fifo_empty[gi] ? in_rob[gi]
                                             : mem_reg[rd_ptr_reg][ENT_W-1:DATA_W];
      assign cand_value[gi] = fifo_empty[gi] ? in_value[gi]
                                             : mem_reg[rd_ptr_reg][DATA_W-1:0];

      // A winning arrival into an empty FIFO bypasses storage entirely.
      // Every other accepted arrival is queued at the tail.
      assign pop  = win[gi] & ~fifo_empty[gi];
      assign push = xfer & ~(win[gi] & fifo_empty[gi]);

      // Storage array with no reset, so the tools can map it to RAM.
      always_ff @(posedge clk) begin
        if (push) begin
          mem_reg[wr_ptr_reg] <= {in_rob[gi], in_value[gi]};
        end
      end

      // push and pop are already gated by rdy, so a freeze leaves the
      // pointers and the count alone. A power-of-two DEPTH lets the
      // pointers wrap naturally.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
          count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic grant_lsb;

`ifdef CDB_ARB_FIXED_PRI_EN
  // The LSB wins whenever it has a candidate.
  assign grant_lsb = cand_valid[1];
`else
  // 1 means the LSB took the last contended cycle.
  logic last_grant_reg;

  assign grant_lsb = (cand_valid[0] & cand_valid[1]) ? ~last_grant_reg
                                                     : cand_valid[1];

  // Grant history moves only on a real contention, and it resets to LSB so
  // that the ALU wins the first contention.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      last_grant_reg <= 1'b1;
    end else if (active && (&cand_valid)) begin
      last_grant_reg <= grant_lsb;
    end
  end
`endif

  assign win[0] = active & cand_valid[0] & ~grant_lsb;
  assign win[1] = active & cand_valid[1] &  grant_lsb;

  // ---------------------------------------------------------------------------
  // Registered broadcast
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_rob   <= '0;
      cdb_value <= '0;
      cdb_src   <= 1'b0;
    end else if (|win) begin
      cdb_valid <= 1'b1;
      cdb_rob   <= cand_rob[win[1]];
      cdb_value <= cand_value[win[1]];
      cdb_src   <= win[1];
    end else begin
      // The payload is held; only the valid pulse drops.
      cdb_valid <= 1'b0;
    end
  end

endmodule
